// File: rtl/hdmi_cmd_rx_if.sv
// Stream bundle for the HDMI command receiver: deserializer words in, recovered commands out.
// The master side is the receiver (it sources the AXI-Stream); slave is the surrounding system.
interface hdmi_cmd_rx_if;
  logic [29:0] raw_data;
  logic [31:0] commands_tdata;
  logic        commands_tvalid;
  logic        commands_tready;
  logic [2:0]  lane_locked;
  logic        overflow;

  modport master (
    input  raw_data, commands_tready,
    output commands_tdata, commands_tvalid, lane_locked, overflow
  );
  modport slave (
    output raw_data, commands_tready,
    input  commands_tdata, commands_tvalid, lane_locked, overflow
  );
endinterface

// File: rtl/hdmi_cmd_rx.sv
// HDMI command receiver: per-lane word alignment on TMDS control tokens, then
// non-idle 30-bit commands queued into a small FIFO feeding an AXI-Stream master.
module hdmi_cmd_rx #(
  parameter int LOCK_COUNT   = 8,
  parameter int LOSS_TIMEOUT = 4096,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic         clk_px,
  input  logic         resetn_async,
  hdmi_cmd_rx_if.master bus
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 10;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int HW        = $clog2(LOCK_COUNT + 1);
  localparam int IW        = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [VEC_W-1:0] NOOP = 10'b1101010100;

  typedef enum logic {SEARCH, LOCKED} state_t;

  function automatic logic is_token(input logic [VEC_W-1:0] w);
    return w inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  endfunction

  // Assert asynchronously, release two clocks later so all state leaves reset together.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk_px or negedge resetn_async) begin
    if (!resetn_async) rst_sync_q <= 2'b00;
    else               rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [NUM_LANES-1:0][VEC_W-1:0] sym;
  logic [NUM_LANES-1:0]            locked;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [VEC_W-1:0]   raw_q, prev_q, sym_q, win;
    logic [2*VEC_W-1:0] hist;
    logic [3:0]         offset_q;
    logic [HW-1:0]      hit_q;
    logic [IW-1:0]      idle_q;
    state_t             state_q;
    logic               locked_q;

    assign hist = {raw_q, prev_q};
    assign win  = hist[offset_q +: VEC_W];

    always_ff @(posedge clk_px or negedge rst_n) begin
      if (!rst_n) begin
        raw_q    <= '0;
        prev_q   <= '0;
        sym_q    <= '0;
        offset_q <= '0;
        hit_q    <= '0;
        idle_q   <= '0;
        state_q  <= SEARCH;
        locked_q <= 1'b0;
      end else begin
        raw_q  <= bus.raw_data[l*VEC_W +: VEC_W];
        prev_q <= raw_q;
        sym_q  <= win;
        case (state_q)
          SEARCH: begin
            if (is_token(win)) begin
              if (hit_q == HW'(LOCK_COUNT - 1)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                hit_q    <= '0;
                idle_q   <= '0;
              end else begin
                hit_q <= hit_q + 1'b1;
              end
            end else begin
              hit_q    <= '0;
              offset_q <= (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            end
          end
          LOCKED: begin
            // Offset is frozen here; losing lock keeps it so a brief outage relocks fast.
            if (is_token(win)) begin
              idle_q <= '0;
            end else if (idle_q == IW'(LOSS_TIMEOUT - 1)) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              hit_q    <= '0;
              idle_q   <= '0;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end

    assign sym[l]    = sym_q;
    assign locked[l] = locked_q;
  end

  // Output FIFO
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          overflow_q;
  logic          empty, full, all_noop, wr_req, rd, wr;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign all_noop = (sym == {NUM_LANES{NOOP}});
  assign wr_req   = (&locked) && !all_noop;
  assign rd       = !empty && bus.commands_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr       = wr_req && (!full || rd);

  always_ff @(posedge clk_px or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
      if (wr_req && !wr) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_px) begin
    if (wr) mem[wp_q] <= {2'b00, sym};
  end

  assign bus.commands_tvalid = !empty;
  assign bus.commands_tdata  = empty ? 32'd0 : mem[rp_q];
  assign bus.lane_locked     = locked;
  assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_hdmi_cmd_rx.sv
// Directed + randomized bench for hdmi_cmd_rx; lanes are driven as a serial symbol stream
// cut into words at a fixed bit shift, and outputs are compared with the symbols sent.
module tb_hdmi_cmd_rx;
  localparam int LOCK_COUNT   = 8;
  localparam int LOSS_TIMEOUT = 4096;
  localparam int FIFO_DEPTH   = 16;
  localparam int SHIFT        = 3;
  localparam int LOCK_BOUND   = 10*LOCK_COUNT + 12;
  localparam logic [9:0] NOOP = 10'b1101010100;

  logic clk_px = 1'b0;
  logic resetn_async = 1'b0;
  hdmi_cmd_rx_if bus();

  hdmi_cmd_rx #(.LOCK_COUNT(LOCK_COUNT), .LOSS_TIMEOUT(LOSS_TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH))
    dut (.clk_px(clk_px), .resetn_async(resetn_async), .bus(bus));

  always #5 clk_px = ~clk_px;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0]  prev_sym [3];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One word per lane: the serial stream is shifted SHIFT bits against the word boundary.
  // Any beat accepted at the coming edge is captured before the edge.
  task automatic tick(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
    logic [9:0]  cur [3];
    logic [19:0] pair;
    cur[0] = s0; cur[1] = s1; cur[2] = s2;
    for (int l = 0; l < 3; l++) begin
      pair = {cur[l], prev_sym[l]} >> (10 - SHIFT);
      bus.raw_data[l*10 +: 10] = pair[9:0];
      prev_sym[l] = cur[l];
    end
    if (bus.commands_tvalid && bus.commands_tready) got_q.push_back(bus.commands_tdata);
    @(posedge clk_px); #1;
  endtask

  task automatic send_data(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
    tick(s0, s1, s2);
    exp_q.push_back({2'b00, s2, s1, s0});
  endtask

  task automatic rand_word(output logic [9:0] s0, output logic [9:0] s1, output logic [9:0] s2);
    do begin
      s0 = 10'($urandom_range(0, 1023));
      s1 = 10'($urandom_range(0, 1023));
      s2 = 10'($urandom_range(0, 1023));
    end while (s0 == NOOP && s1 == NOOP && s2 == NOOP);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(NOOP, NOOP, NOOP);
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_data"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [9:0]  w0, w1, w2;
    logic [29:0] dword;
    int lat, nbeats, nbad, k;

    for (int l = 0; l < 3; l++) prev_sym[l] = '0;
    bus.raw_data = '0;
    bus.commands_tready = 1'b0;

    // Reset held with random input, then released
    for (int i = 0; i < 5; i++) begin
      rand_word(w0, w1, w2);
      tick(w0, w1, w2);
    end
    check("rst_tvalid", 32'(bus.commands_tvalid), 32'd0);
    check("rst_locked", 32'(bus.lane_locked), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    resetn_async = 1'b1;
    idle(2);
    check("rel_tvalid", 32'(bus.commands_tvalid), 32'd0);
    check("rel_locked", 32'(bus.lane_locked), 32'd0);
    check("rel_overflow", 32'(bus.overflow), 32'd0);

    // Lock on shifted NOOP stream, no writes
    bus.commands_tready = 1'b1;
    got_q.delete();
    for (int i = 0; i < LOCK_BOUND && bus.lane_locked !== 3'b111; i++) idle(1);
    check("lock", 32'(bus.lane_locked), 32'h7);
    idle(4);
    check("lock_no_writes", 32'(got_q.size()), 32'd0);

    // Single data word amid NOOPs: correct value implies offset 3 on every lane
    dword = 30'h1555AAAA;
    tick(dword[9:0], dword[19:10], dword[29:20]);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      if (lat < 0 && got_q.size() != 0) lat = i;
    end
    check("data_beats", 32'(got_q.size()), 32'd1);
    if (got_q.size() != 0) check("data_value", got_q[0], 32'h1555AAAA);
    check("data_latency_ok", 32'(lat >= 2 && lat <= 6), 32'd1);
    got_q.delete();

    // Randomized bursts with random backpressure, never exceeding FIFO depth
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(4, FIFO_DEPTH);
      for (int i = 0; i < k; i++) begin
        bus.commands_tready = 1'($urandom_range(0, 1));
        rand_word(w0, w1, w2);
        send_data(w0, w1, w2);
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          bus.commands_tready = 1'($urandom_range(0, 1));
          idle(1);
        end
      end
      bus.commands_tready = 1'b1;
      idle(FIFO_DEPTH + 8);
      compare_queues("rand");
    end
    check("no_overflow_yet", 32'(bus.overflow), 32'd0);

    // Backpressure: 20 words into a 16-deep FIFO
    bus.commands_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_word(w0, w1, w2);
      send_data(w0, w1, w2);
    end
    idle(6);
    check("bp_overflow", 32'(bus.overflow), 32'd1);
    check("bp_tvalid", 32'(bus.commands_tvalid), 32'd1);
    check("bp_head_stable", bus.commands_tdata, exp_q[0]);
    bus.commands_tready = 1'b1;
    idle(FIFO_DEPTH + 8);
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    compare_queues("bp_drain");
    check("bp_overflow_sticky", 32'(bus.overflow), 32'd1);
    check("bp_empty_tvalid", 32'(bus.commands_tvalid), 32'd0);
    check("bp_empty_tdata", bus.commands_tdata, 32'd0);

    // Loss of lock on lane 1: mixed words are written until it unlocks
    got_q.delete();
    for (int i = 0; i < LOSS_TIMEOUT + 10; i++) tick(NOOP, 10'd0, NOOP);
    check("loss_locked", 32'(bus.lane_locked), 32'h5);
    nbeats = got_q.size();
    nbad = 0;
    foreach (got_q[i]) if (got_q[i] !== {2'b00, NOOP, 10'd0, NOOP}) nbad++;
    check("loss_beat_values", 32'(nbad), 32'd0);
    check("loss_beat_count_ok", 32'(nbeats >= LOSS_TIMEOUT-2 && nbeats <= LOSS_TIMEOUT), 32'd1);
    got_q.delete();
    for (int i = 0; i < 20; i++) tick(NOOP, 10'd0, NOOP);
    check("loss_writes_stop", 32'(got_q.size()), 32'd0);

    // Relock after restoring NOOPs, then data flows again
    for (int i = 0; i < LOCK_BOUND && bus.lane_locked !== 3'b111; i++) idle(1);
    check("relock", 32'(bus.lane_locked), 32'h7);
    idle(4);
    check("relock_no_writes", 32'(got_q.size()), 32'd0);
    rand_word(w0, w1, w2);
    send_data(w0, w1, w2);
    idle(10);
    compare_queues("relock_data");

    // Async reset with FIFO partly filled
    bus.commands_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_word(w0, w1, w2);
      send_data(w0, w1, w2);
    end
    idle(6);
    check("pre_arst_tvalid", 32'(bus.commands_tvalid), 32'd1);
    resetn_async = 1'b0;
    #1;
    check("arst_tvalid", 32'(bus.commands_tvalid), 32'd0);
    check("arst_tdata", bus.commands_tdata, 32'd0);
    check("arst_locked", 32'(bus.lane_locked), 32'd0);
    check("arst_overflow", 32'(bus.overflow), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
